// File: rtl/load_store_unit.sv
// Load/store unit between a request/response handshake and a word-wide synchronous memory.
// Byte and half stores are done as a read-modify-write of the containing word.
module load_store_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   input  logic [31:0]           mem_rdata
);

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_BAD  = 2'b11;
   localparam logic [ADDR_WIDTH-1:0] WORD_LIMIT = ADDR_WIDTH'(MEM_WORDS);

   typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RSP} state_t;

   state_t state;
   state_t state_next;

   logic                  we_q;
   logic [1:0]            size_q;
   logic                  signed_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [31:0]           rdata_q;
   logic                  err_q;

   logic                  accept;
   logic                  req_bad;
   logic [ADDR_WIDTH-1:0] req_index;
   logic [ADDR_WIDTH-1:0] word_index;
   logic [4:0]            lane_shift;
   logic [31:0]           lane_data;
   logic [31:0]           load_data;
   logic [31:0]           lane_mask;
   logic [31:0]           lane_wdata;
   logic [31:0]           merged;

   assign accept     = req_valid && (state == IDLE);
   assign req_index  = req_addr >> 2;
   assign word_index = addr_q >> 2;
   assign lane_shift = {addr_q[1:0], 3'b000};

   // Rejection is decided from the raw request so an error can answer one cycle after acceptance.
   always_comb begin
      req_bad = (req_size == SIZE_BAD)
             || ((req_size == SIZE_HALF) && req_addr[0])
             || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
             || (req_index >= WORD_LIMIT);
   end

   // Load path: bring the addressed lane down to bit 0, then extend it.
   always_comb begin
      lane_data = mem_rdata >> lane_shift;
      case (size_q)
         SIZE_BYTE: load_data = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
         SIZE_HALF: load_data = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
         default:   load_data = lane_data;
      endcase
   end

   always_comb begin
      if (size_q == SIZE_HALF) begin
         lane_mask  = 32'h0000_FFFF << lane_shift;
         lane_wdata = {16'h0000, wdata_q[15:0]} << lane_shift;
      end else begin
         lane_mask  = 32'h0000_00FF << lane_shift;
         lane_wdata = {24'h00_0000, wdata_q[7:0]} << lane_shift;
      end
      merged = (mem_rdata & ~lane_mask) | lane_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      mem_we     = 1'b0;
      mem_wdata  = 32'h0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_bad) begin
                  state_next = RSP;
               end else if (req_we && (req_size == SIZE_WORD)) begin
                  state_next = WR;
               end else begin
                  state_next = RD;
               end
            end
         end
         RD: begin
            state_next = MERGE;
         end
         MERGE: begin
            state_next = RSP;
            if (we_q) begin
               mem_we    = 1'b1;
               mem_wdata = merged;
            end
         end
         WR: begin
            state_next = RSP;
            mem_we     = 1'b1;
            mem_wdata  = wdata_q;
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // A store caught by reset is abandoned outright, including its write strobe.
      if (rst) begin
         mem_we    = 1'b0;
         mem_wdata = 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else if (accept) begin
         we_q     <= req_we;
         size_q   <= req_size;
         signed_q <= req_signed;
         addr_q   <= req_addr;
         wdata_q  <= req_wdata;
         rdata_q  <= 32'h0;
         err_q    <= req_bad;
      end else if ((state == MERGE) && !we_q) begin
         rdata_q  <= load_data;
      end
   end

   assign mem_addr  = word_index;
   assign mem_raddr = word_index;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a byte-level memory model predicts every response
// and write, and a per-cycle compare process checks the handshake and memory port against it.
module tb_load_store_unit;

   localparam int AW    = 32;
   localparam int WORDS = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic          req_signed;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [AW-1:0] mem_raddr;
   logic [31:0]   mem_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_WIDTH(AW), .MEM_WORDS(WORDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_raddr  (mem_raddr),
      .mem_rdata  (mem_rdata)
   );

   // Attached synchronous memory: read data appears one cycle after the index is sampled.
   logic [31:0] bench_mem [WORDS];
   always @(posedge clk) begin
      if (mem_we && (mem_addr < 32'(WORDS))) bench_mem[mem_addr[5:0]] <= mem_wdata;
      mem_rdata <= (mem_raddr < 32'(WORDS)) ? bench_mem[mem_raddr[5:0]] : 32'h0;
   end

   logic [31:0] ref_mem [WORDS];

   int          errors = 0;
   int          checks = 0;
   int          cycle  = 0;
   bit          chk_en = 1'b0;
   bit          busy   = 1'b0;
   int          acc_c  = 0;
   int          k;
   bit          exp_err;
   bit          exp_write;
   int          exp_lat;
   int          exp_wcyc;
   logic [31:0] exp_rdata;
   logic [31:0] exp_wword;
   logic [31:0] exp_idx = 32'h0;
   logic [31:0] last_wword = 32'h0;
   logic [31:0] last_waddr = 32'h0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Per-cycle comparison against the expectation of the request in flight.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         k = cycle - acc_c;
         checkOutput("req_ready", 32'(req_ready), 32'(!busy || (k == 0)));
         if (busy && (k >= exp_lat)) begin
            checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
            checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
         end else begin
            checkOutput("rsp_valid", 32'(rsp_valid), 32'd0);
         end
         if (busy && exp_write && (k == exp_wcyc)) begin
            checkOutput("mem_we", 32'(mem_we), 32'd1);
            checkOutput("mem_wdata", mem_wdata, exp_wword);
         end else begin
            checkOutput("mem_we", 32'(mem_we), 32'd0);
            checkOutput("mem_wdata", mem_wdata, 32'd0);
         end
         if (!busy || (k > 0)) begin
            checkOutput("mem_addr", mem_addr, exp_idx);
            checkOutput("mem_raddr", mem_raddr, exp_idx);
         end
         if (mem_we) begin
            last_wword = mem_wdata;
            last_waddr = mem_addr;
         end
      end
   end

   // Issue one request, predict its outcome from byte-level rules, and complete the response.
   task automatic applyStimulus(input bit we, input logic [1:0] size, input bit sgn,
                                input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                                output logic [31:0] got_rdata, output bit got_err, output int got_lat);
      int          nbytes;
      int          lane;
      int          widx;
      int          n;
      bit          bad;
      logic [31:0] word;
      logic [31:0] val;
      logic [31:0] mask;
      widx   = int'(addr >> 2);
      lane   = int'(addr % 4);
      nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      bad    = (size == 2'd3) || ((addr % nbytes) != 0) || (widx >= WORDS);
      exp_err   = bad;
      exp_idx   = addr >> 2;
      exp_write = we && !bad;
      exp_lat   = bad ? 1 : (we && (size == 2'd2)) ? 2 : 3;
      exp_wcyc  = (size == 2'd2) ? 1 : 2;
      exp_rdata = 32'h0;
      exp_wword = 32'h0;
      if (!bad) begin
         word = ref_mem[widx];
         if (we) begin
            for (int b = 0; b < nbytes; b++) word[8*(lane+b) +: 8] = wdata[8*b +: 8];
            ref_mem[widx] = word;
            exp_wword     = word;
         end else begin
            mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nbytes)) - 32'h1);
            val  = (word >> (8*lane)) & mask;
            if (sgn && (nbytes < 4) && val[8*nbytes-1]) val = val | ~mask;
            exp_rdata = val;
         end
      end
      acc_c      = cycle;
      busy       = 1'b1;
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      n = 0;
      while (!rsp_valid && (n < 10)) begin
         @(posedge clk); #1;
         n++;
      end
      got_lat   = cycle - acc_c;
      got_rdata = rsp_rdata;
      got_err   = rsp_err;
      if (!rsp_valid) begin
         checkOutput("rsp_timeout", 32'd0, 32'd1);
         busy = 1'b0;
         return;
      end
      repeat (stall) begin
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      busy      = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] r;
      bit          e;
      int          l;
      for (int i = 0; i < WORDS; i++) begin
         bench_mem[i] = 32'h0;
         ref_mem[i]   = 32'h0;
      end
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      rsp_ready  = 1'b0;

      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
      checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
      checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
      checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
      checkOutput("reset_mem_addr", mem_addr, 32'd0);
      checkOutput("reset_mem_raddr", mem_raddr, 32'd0);
      @(posedge clk); #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      $display("[TB] reset released, first request issued on first active cycle");

      // Word store then load, starting on the very first cycle out of reset.
      applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, r, e, l);
      checkOutput("lit_wstore_lat", 32'(l), 32'd2);
      checkOutput("lit_wstore_addr", last_waddr, 32'd4);
      checkOutput("lit_wstore_data", last_wword, 32'hDEAD_BEEF);
      checkOutput("lit_wstore_rdata", r, 32'h0);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, r, e, l);
      checkOutput("lit_wload_lat", 32'(l), 32'd3);
      checkOutput("lit_wload_rdata", r, 32'hDEAD_BEEF);

      // Byte read-modify-write and sign/zero extension.
      applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 0, r, e, l);
      applyStimulus(1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFF_FFAB, 0, r, e, l);
      checkOutput("lit_rmw_lat", 32'(l), 32'd3);
      checkOutput("lit_rmw_word", last_wword, 32'h11AB_3344);
      applyStimulus(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 0, r, e, l);
      checkOutput("lit_lb_signed", r, 32'hFFFF_FFAB);
      applyStimulus(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, r, e, l);
      checkOutput("lit_lh_unsigned", r, 32'h0000_11AB);

      // Half store in the upper lane, loads of assorted lanes and widths.
      applyStimulus(1'b1, 2'd1, 1'b0, 32'h16, 32'h1234_BEEF, 0, r, e, l);
      applyStimulus(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 0, r, e, l);
      checkOutput("lit_lh_signed", r, 32'hFFFF_BEEF);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0, r, e, l);
      checkOutput("lit_lw_half_merged", r, 32'hBEEF_0000);
      applyStimulus(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, r, e, l);
      checkOutput("lit_lbu_lane3", r, 32'h0000_0011);
      applyStimulus(1'b1, 2'd0, 1'b0, 32'h03, 32'h0000_0080, 0, r, e, l);
      applyStimulus(1'b0, 2'd0, 1'b1, 32'h03, 32'h0, 0, r, e, l);
      checkOutput("lit_lb_signed_lane3", r, 32'hFFFF_FF80);
      applyStimulus(1'b0, 2'd1, 1'b1, 32'h02, 32'h0, 0, r, e, l);
      applyStimulus(1'b1, 2'd0, 1'b0, 32'hFC, 32'h0000_005A, 0, r, e, l);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 0, r, e, l);
      checkOutput("lit_last_word", r, 32'h0000_005A);

      // Rejected requests.
      applyStimulus(1'b1, 2'd1, 1'b0, 32'h11, 32'h5555_5555, 0, r, e, l);
      checkOutput("lit_err_half_lat", 32'(l), 32'd1);
      checkOutput("lit_err_half", 32'(e), 32'd1);
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0, r, e, l);
      checkOutput("lit_err_word", 32'(e), 32'd1);
      applyStimulus(1'b1, 2'd3, 1'b0, 32'h20, 32'h7777_7777, 0, r, e, l);
      checkOutput("lit_err_size", 32'(e), 32'd1);
      checkOutput("lit_err_size_rdata", r, 32'h0);
      applyStimulus(1'b1, 2'd2, 1'b0, 32'(4*WORDS), 32'h9999_9999, 0, r, e, l);
      checkOutput("lit_err_range_lat", 32'(l), 32'd1);
      checkOutput("lit_err_range", 32'(e), 32'd1);

      // Backpressure on a load, an error and a sub-word store.
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, r, e, l);
      checkOutput("lit_stall_rdata", r, 32'h11AB_3344);
      applyStimulus(1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 3, r, e, l);
      applyStimulus(1'b1, 2'd0, 1'b0, 32'h15, 32'h0000_00C3, 2, r, e, l);
      checkOutput("lit_stall_rmw_word", last_wword, 32'hBEEF_C300);

      // Reset while a byte store sits in its merge cycle.
      applyStimulus(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D, 0, r, e, l);
      chk_en     = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = 32'h21;
      req_wdata  = 32'h0000_0055;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      @(posedge clk); #1;
      rst        = 1'b1;
      @(posedge clk); #1;
      rst        = 1'b0;
      exp_idx    = 32'h0;
      @(negedge clk);
      checkOutput("rstmid_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rstmid_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk_en = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, r, e, l);
      checkOutput("lit_after_rst_load", r, 32'h11AB_3344);

      repeat (3) @(posedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte-address width of the request and memory ports.
REQ-002 The block SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit words in the attached data memory.
REQ-003 The block SHALL have ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend load data.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data.
- rsp_err  out  1  request rejected.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory write word index.
- mem_wdata  out  32  memory write word.
- mem_raddr  out  ADDR_WIDTH  memory read word index.
- mem_rdata  in  32  memory read word, valid one cycle after mem_raddr is sampled.

Function
REQ-004 The FSM SHALL have the states IDLE, RD, MERGE, WR and RSP, and req_ready SHALL be 1 only in IDLE.
REQ-005 On req_valid&req_ready, the unit SHALL register we, size, signed, addr and wdata; inputs are ignored at all other times.
REQ-006 An accepted request SHALL be an error, with IDLE->RSP, rsp_err=1, rsp_rdata=0 and no memory write, in any of these cases:
- size=11.
- half with addr[0]=1.
- word with addr[1:0]!=0.
- addr[ADDR_WIDTH-1:2] >= MEM_WORDS.
REQ-007 mem_addr and mem_raddr SHALL both equal the registered addr[ADDR_WIDTH-1:2] zero-extended, and SHALL hold from acceptance until the next acceptance.
REQ-008 A valid load SHALL follow IDLE->RD->MERGE->RSP.
REQ-009 In MERGE, a load SHALL select the lane at addr[1:0] (little-endian) from mem_rdata, then zero- or sign-extend it per req_signed, and register the result as rsp_rdata.
REQ-010 A valid word store SHALL follow IDLE->WR->RSP, with mem_we=1 and mem_wdata=wdata for exactly the WR cycle.
REQ-011 A valid byte or half store SHALL perform read-modify-write along IDLE->RD->MERGE->RSP.
REQ-012 In MERGE for a byte or half store, mem_wdata SHALL equal mem_rdata with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0], and mem_we SHALL be 1 for that single cycle.
REQ-013 mem_we SHALL be 0 and mem_wdata SHALL be 0 in every cycle other than REQ-010/REQ-012 write cycles.
REQ-014 Latency SHALL be counted from the acceptance cycle T to the first rsp_valid cycle:
- loads and sub-word stores: T+3.
- word stores: T+2.
- errors: T+1.
REQ-015 In RSP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be stable until rsp_valid&rsp_ready; the FSM then returns to IDLE.
REQ-016 Back-to-back requests SHALL be separated by at least one IDLE cycle. No request is accepted in the cycle rsp_ready completes a response.
REQ-017 Stores SHALL return rsp_rdata=0.
REQ-018 Every store SHALL write memory exactly once, and a rejected request SHALL never assert mem_we.

Reset
REQ-019 While rst=1 at a clk edge, the unit SHALL enter IDLE.
REQ-020 After that edge, all outputs SHALL be 0 except req_ready=1.
REQ-021 Reset asserted mid-operation SHALL abandon the in-flight request: no response is produced, and no mem_we occurs after the rst edge.
REQ-022 The first request SHALL be accepted on the first cycle with rst=0.

Verification
REQ-023 Word store then load: store addr 0x10, word, data 0xDEADBEEF; then load addr 0x10, word -> one mem_we with mem_addr=4 and mem_wdata=0xDEADBEEF, rsp at T+2; load rsp_rdata=0xDEADBEEF at T+3.
REQ-024 Byte RMW: memory word 4 = 0x11223344; store byte addr 0x12 data 0xAB -> mem_wdata=0x11AB3344 in MERGE.
REQ-025 Signed load: word 4 = 0x11AB3344; load byte signed at 0x12 -> rsp_rdata=0xFFFFFFAB; load half unsigned at 0x12 -> 0x000011AB.
REQ-026 Errors: half at 0x11, word at 0x12, size=11, and a word at byte address 4*MEM_WORDS -> each gives rsp_err=1 at T+1 with mem_we never 1.
REQ-027 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err held; req_ready=0; no further memory traffic.
REQ-028 Reset in MERGE of a byte store -> no mem_we after reset; IDLE with req_ready=1 on the next cycle.
